// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack
//   Post-add/sub normalizer for IEEE-754 single precision. Takes a raw
//   25-bit mantissa sum (carry bit 24, hidden bit 23) with guard/round/
//   sticky bits and the larger operand's biased exponent. It normalizes
//   the sum (one right shift or up to 24 single-bit left shifts), rounds
//   to nearest-even, detects overflow, underflow and zero, and packs the
//   32-bit result. Only one operation is in flight at a time.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready is high only when idle
//   in_sum[24:0]          raw unsigned mantissa sum
//   in_grs[2:0]           guard, round, sticky bits below in_sum[0]
//   in_exp[7:0]           biased exponent of the larger operand (1..254)
//   in_sign               result sign
//   out_valid / out_ready output handshake; the result holds while stalled
//   out_result[31:0]      packed {sign, exp[7:0], frac[22:0]}
//   out_flags[2:0]        {overflow, underflow, zero}
module fp_normalize_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_sum,
    input  logic [2:0]  in_grs,
    input  logic [7:0]  in_exp,
    input  logic        in_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [24:0]        r_sum;
    logic               r_g;
    logic               r_r;
    logic               r_s;
    logic signed [9:0]  r_exp;
    logic               r_sign;
    logic [4:0]         r_ncnt;
    logic [31:0]        r_result;
    logic [2:0]         r_flags;

    logic               w_is_zero;
    logic               w_norm_go;
    logic [24:0]        w_shl;
    logic signed [9:0]  w_exp_dec;
    logic               w_norm_last;

    logic               w_inc;
    logic [24:0]        w_rsum;
    logic [23:0]        w_rman;
    logic signed [9:0]  w_rexp;
    logic               w_ovf;
    logic               w_den;
    logic [31:0]        w_pack;
    logic [2:0]         w_pflags;

    assign w_is_zero = (r_sum == '0) && ({r_g, r_r, r_s} == 3'b000);

    // A left shift is allowed while the hidden bit is clear and the exponent
    // can still drop without going below the denormal exponent of 1.
    assign w_norm_go = !r_sum[23] && (r_exp > 10'sd1);
    assign w_shl     = {r_sum[23:0], r_g};
    assign w_exp_dec = r_exp - 10'sd1;

    // The exit decision looks at the value being shifted in this cycle, so
    // the shift that sets the hidden bit is also the last NORM cycle. The
    // count bound only matters for inputs whose sum is zero and whose
    // guard bit is clear.
    assign w_norm_last = w_shl[23] || (w_exp_dec <= 10'sd1) || (r_ncnt == 5'd23);

    // Round to nearest, ties to even.
    assign w_inc  = r_g & (r_r | r_s | r_sum[0]);
    assign w_rsum = r_sum + {24'd0, w_inc};
    assign w_rman = w_rsum[24] ? w_rsum[24:1] : w_rsum[23:0];
    assign w_rexp = w_rsum[24] ? (r_exp + 10'sd1) : r_exp;
    assign w_ovf  = (w_rexp >= 10'sd255);
    // Still no hidden bit after rounding: pack as denormal (exponent field 0).
    // A denormal rounding up into bit 23 keeps exponent 1 and packs normally.
    assign w_den  = !w_rman[23];

    always_comb begin
        w_pack   = '0;
        w_pflags = '0;
        if (w_ovf) begin
            w_pack   = {r_sign, 8'hFF, 23'd0};
            w_pflags = 3'b100;
        end else begin
            w_pack      = {r_sign, (w_den ? 8'h00 : w_rexp[7:0]), w_rman[22:0]};
            w_pflags[1] = w_den;
            w_pflags[0] = (w_rman == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_is_zero) begin
                    w_next = S_DONE;
                end else if (r_sum[24] || r_sum[23]) begin
                    w_next = S_ROUND;
                end else begin
                    w_next = S_NORM;
                end
            end
            S_NORM: begin
                if (!w_norm_go || w_norm_last) begin
                    w_next = S_ROUND;
                end
            end
            S_ROUND: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum    <= '0;
            r_g      <= 1'b0;
            r_r      <= 1'b0;
            r_s      <= 1'b0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_ncnt   <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sum  <= in_sum;
                        r_g    <= in_grs[2];
                        r_r    <= in_grs[1];
                        r_s    <= in_grs[0];
                        r_exp  <= {2'b00, in_exp};
                        r_sign <= in_sign;
                        r_ncnt <= '0;
                    end
                end
                S_CHECK: begin
                    if (w_is_zero) begin
                        r_result <= {r_sign, 31'd0};
                        r_flags  <= 3'b001;
                    end else if (r_sum[24]) begin
                        r_sum <= {1'b0, r_sum[24:1]};
                        r_g   <= r_sum[0];
                        r_r   <= r_g;
                        r_s   <= r_r | r_s;
                        r_exp <= r_exp + 10'sd1;
                    end
                end
                S_NORM: begin
                    if (w_norm_go) begin
                        r_sum  <= w_shl;
                        r_g    <= r_r;
                        r_r    <= r_s;
                        r_exp  <= w_exp_dec;
                        r_ncnt <= r_ncnt + 5'd1;
                    end
                end
                S_ROUND: begin
                    r_result <= w_pack;
                    r_flags  <= w_pflags;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;
    assign out_flags  = r_flags;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// tb_fp_normalize_pack
//   Table of operand/result vectors for fp_normalize_pack. Each accepted
//   operation pushes its expected result onto a scoreboard queue, which is
//   popped and compared when the DUT completes the output handshake.
//   Latency counts rising edges from the accept edge (counted as 1) to the
//   edge after which out_valid is high.
module tb_fp_normalize_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_sum;
    logic [2:0]  in_grs;
    logic [7:0]  in_exp;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    fp_normalize_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_grs     (in_grs),
        .in_exp     (in_exp),
        .in_sign    (in_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] sum;
        logic [2:0]  grs;
        logic [7:0]  exp;
        logic        sign;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        int          hold;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];
    vec_t sb [$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    task automatic do_op(input int idx, input bit align);
        vec_t        v;
        vec_t        e;
        int          lat;
        bit          seen;
        bit          busy_ok;
        bit          stable_ok;
        logic [31:0] snap_r;
        logic [2:0]  snap_f;
        v = vecs[idx];
        if (align) @(negedge clk);
        in_sum    = v.sum;
        in_grs    = v.grs;
        in_exp    = v.exp;
        in_sign   = v.sign;
        in_valid  = 1'b1;
        out_ready = (v.hold == 0);
        chk($sformatf("v%0d_ready_before", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(v);
        lat     = 1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
        end
        chk($sformatf("v%0d_ready_low_busy", idx), {31'd0, busy_ok}, 32'd1);
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL v%0d_timeout: out_valid not seen within 60 cycles", idx);
            void'(sb.pop_front());
            out_ready = 1'b1;
            return;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_ready_low_done", idx), {31'd0, in_ready}, 32'd0);
        if (v.hold > 0) begin
            snap_r    = out_result;
            snap_f    = out_flags;
            stable_ok = 1'b1;
            for (int h = 0; h < v.hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                if (out_valid !== 1'b1 || out_result !== snap_r ||
                    out_flags !== snap_f || in_ready !== 1'b0) stable_ok = 1'b0;
            end
            chk($sformatf("v%0d_backpressure_hold", idx), {31'd0, stable_ok}, 32'd1);
            out_ready = 1'b1;
        end
        // Offer a new input in the handshake cycle; it must not be taken.
        in_valid = 1'b1;
        e = sb.pop_front();
        chk($sformatf("v%0d_result", idx), out_result, e.res);
        chk($sformatf("v%0d_flags", idx), {29'd0, out_flags}, {29'd0, e.flg});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk($sformatf("v%0d_idle_after", idx), {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        //            sum          grs     exp    sign  result        flags   lat hold
        vecs[0]  = '{25'h0800000, 3'b000, 8'd127, 1'b0, 32'h3F800000, 3'b000, 3,  0};
        vecs[1]  = '{25'h1000000, 3'b000, 8'd127, 1'b0, 32'h40000000, 3'b000, 3,  0};
        vecs[2]  = '{25'h1000000, 3'b000, 8'd254, 1'b0, 32'h7F800000, 3'b100, 3,  0};
        vecs[3]  = '{25'h0000001, 3'b000, 8'd127, 1'b0, 32'h34000000, 3'b000, 26, 0};
        vecs[4]  = '{25'h0FFFFFF, 3'b100, 8'd127, 1'b0, 32'h40000000, 3'b000, 3,  0};
        vecs[5]  = '{25'h0800000, 3'b100, 8'd127, 1'b0, 32'h3F800000, 3'b000, 3,  0};
        vecs[6]  = '{25'h0000000, 3'b000, 8'd127, 1'b1, 32'h80000000, 3'b001, 2,  0};
        vecs[7]  = '{25'h0800001, 3'b100, 8'd127, 1'b0, 32'h3F800002, 3'b000, 3,  0};
        vecs[8]  = '{25'h1000001, 3'b000, 8'd127, 1'b0, 32'h40000000, 3'b000, 3,  0};
        vecs[9]  = '{25'h1000003, 3'b000, 8'd127, 1'b0, 32'h40000002, 3'b000, 3,  5};
        vecs[10] = '{25'h0800001, 3'b011, 8'd127, 1'b0, 32'h3F800001, 3'b000, 3,  0};
        vecs[11] = '{25'h0800000, 3'b101, 8'd127, 1'b0, 32'h3F800001, 3'b000, 3,  0};
        vecs[12] = '{25'h0400000, 3'b100, 8'd127, 1'b0, 32'h3F000001, 3'b000, 4,  0};
        vecs[13] = '{25'h0000100, 3'b000, 8'd3,   1'b0, 32'h00000400, 3'b010, 5,  0};
        vecs[14] = '{25'h0400000, 3'b000, 8'd1,   1'b0, 32'h00400000, 3'b010, 4,  0};
        vecs[15] = '{25'h07FFFFF, 3'b100, 8'd1,   1'b0, 32'h00800000, 3'b000, 4,  0};
        vecs[16] = '{25'h0FFFFFF, 3'b110, 8'd254, 1'b1, 32'hFF800000, 3'b100, 3,  0};
        vecs[17] = '{25'h0000000, 3'b100, 8'd127, 1'b0, 32'h33800000, 3'b000, 27, 0};
        vecs[18] = '{25'h1000000, 3'b000, 8'd130, 1'b1, 32'hC1800000, 3'b000, 3,  0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_grs    = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_out_flags", {29'd0, out_flags}, 32'd0);

        // Release reset and present the first vector in the same step so it
        // is accepted on the very first rising edge.
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            do_op(i, i != 0);
        end

        // Reset in the middle of a long normalization.
        @(negedge clk);
        in_sum   = 25'h0000001;
        in_grs   = 3'b000;
        in_exp   = 8'd127;
        in_sign  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(vecs[3]);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midnorm_reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midnorm_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midnorm_reset_out_result", out_result, 32'd0);
        chk("midnorm_reset_out_flags", {29'd0, out_flags}, 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid || !in_ready) quiet = 1'b0;
        end
        chk("midnorm_reset_no_valid", {31'd0, quiet}, 32'd1);

        do_op(1, 1'b1);
        do_op(3, 1'b1);

        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_normalize_pack.md
FP_NORMALIZE_PACK -- requirements
Module: fp_normalize_pack

Interface
REQ-001 Parameters: none; widths fixed (25-bit raw mantissa sum, 8-bit biased exponent, IEEE-754 single output).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  raw add/sub result presented.
REQ-005 in_ready  output  1  block idle and can accept; high exactly when state is IDLE.
REQ-006 in_sum  input  25  raw unsigned mantissa sum; bit 24 = carry-out, bit 23 = hidden-bit position.
REQ-007 in_grs  input  3  guard, round, sticky bits below in_sum[0], in order [2:0].
REQ-008 in_exp  input  8  biased exponent of the larger operand (1..254).
REQ-009 in_sign  input  1  result sign.
REQ-010 out_valid  output  1  out_result/out_flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_result  output  32  packed IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-013 out_flags  output  3  {overflow, underflow, zero}.

Function
REQ-014 States: IDLE, CHECK, NORM, ROUND, DONE; each transition consumes exactly one clock.
REQ-015 IDLE: on in_valid && in_ready, latch in_sum, in_grs, in_exp, in_sign into working registers (exp held as 10-bit signed); go CHECK.
REQ-016 CHECK, in_sum==0 and in_grs==0: result {sign,31'b0}, zero flag set; go DONE.
REQ-017 CHECK, sum[24]==1: shift mantissa right 1; G<=sum[0], R<=G, S<=R|S; exp+1; go ROUND.
REQ-018 CHECK, sum[24]==0 and sum[23]==1: go ROUND unchanged.
REQ-019 CHECK, otherwise: go NORM.
REQ-020 NORM: per cycle, if sum[23]==0 and exp>1: shift mantissa left 1, shifting in G; G<=R, R<=S, S kept; exp-1; else go ROUND; at most 24 NORM cycles.
REQ-021 NORM exits with sum[23]==0 (exp==1): denormal; exponent field 0 at pack, underflow flag set.
REQ-022 ROUND: round-to-nearest-even; increment mantissa when G && (R || S || sum[0]).
REQ-023 ROUND: increment carrying into bit 24 shifts right 1 and exp+1; denormal rounding into bit 23 packs exponent field 1.
REQ-024 ROUND: exp>=255 after adjustment gives {sign,8'hFF,23'b0}, overflow flag set.
REQ-025 Normal pack: {sign, exp[7:0], sum[22:0]}; go DONE.
REQ-026 DONE: out_valid=1; out_result/out_flags stable while out_valid && !out_ready.
REQ-027 DONE with out_ready=1: return to IDLE next cycle; no new input accepted in that same cycle.
REQ-028 Latency from accept edge to out_valid: 3+N cycles (N = NORM cycles); zero path 2 cycles.
REQ-029 Throughput: one operation in flight; in_ready low in every state except IDLE.

Reset
REQ-030 rst_n low forces state IDLE immediately, asynchronously to clk.
REQ-031 Reset values: out_valid 0, out_result 0, out_flags 0, working registers 0.
REQ-032 Reset in any state, including mid-NORM, discards the in-flight operation; no out_valid pulse follows.
REQ-033 First accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 in_sum=25'h0800000, grs=0, exp=127, sign=0 -> out_result 32'h3F800000, flags 0, out_valid 3 cycles after accept.
REQ-035 in_sum=25'h1000000, exp=127 -> 32'h40000000; with exp=254 -> 32'h7F800000, overflow flag.
REQ-036 in_sum=25'h0000001, grs=0, exp=127 -> 23 NORM cycles, 32'h34000000, out_valid at cycle 26.
REQ-037 in_sum=25'h0FFFFFF, grs=3'b100, exp=127 -> round carry, 32'h40000000.
REQ-037a Tie-even check: in_sum=25'h0800000, grs=3'b100 -> no increment, 32'h3F800000.
REQ-038 in_sum=0, grs=0, sign=1 -> 32'h80000000, zero flag, out_valid 2 cycles after accept.
REQ-038a Backpressure: out_ready low 5 cycles -> result held stable; in_ready stays 0.
REQ-039 Reset during NORM with in_sum=25'h0000001 -> immediate IDLE, in_ready 1, no out_valid.
REQ-039a Next operation after that reset -> correct result.
